// File: rtl/adat_pkg.sv
// ADAT deframer shared definitions: frame geometry, FSM state encoding, group helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adat_pkg;

    localparam int ADAT_CHANNELS       = 8;
    localparam int ADAT_NIBBLES_PER_CH = 6;
    localparam int ADAT_GROUPS         = 49;
    localparam int ADAT_SAMPLE_W       = 24;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        MARKER    = 2'd1,
        NIBBLE    = 2'd2,
        GAP       = 2'd3
    } adat_state_e;

    // Group 0 carries user bits; audio group g closes a channel when g is a multiple of 6.
    function automatic logic is_sample_end(input logic [5:0] grp);
        return (grp != 6'd0) && ((grp % 6'(ADAT_NIBBLES_PER_CH)) == 6'd0);
    endfunction

endpackage

// File: rtl/adat_nibble_shifter.sv
// 4-bit serial-to-parallel converter; done_o flags the bit that completes a nibble.
// Latency: combinational nibble_o/done_o on the completing bit (first bit ends up in [3]).
// Backpressure: none; advances only on shift_i, clr_i restarts the count.
// Ports: clk_i/rst_i clock and sync reset, clr_i restart, shift_i/bit_i serial input,
//        nibble_o assembled nibble (valid with done_o), done_o 4th-bit strobe.
module adat_nibble_shifter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic       bit_i,
    output logic [3:0] nibble_o,
    output logic       done_o
);

    logic [1:0] cnt_q, cnt_d;
    logic [2:0] sh_q,  sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (shift_i) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {sh_q[1:0], bit_i};
        end
    end

    // Only three bits are stored: the 4th arrives on bit_i in the completing cycle.
    assign nibble_o = {sh_q, bit_i};
    assign done_o   = shift_i && !clr_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/adat_frame_deframer.sv
// ADAT frame deframer: splits a decoded bitstream into user nibble + 8 x 24-bit samples, tracks lock.
// Latency: strobes (user/sample/frame/error) one cycle after the accepted bit that causes them.
// Backpressure: none; valid_i low stalls indefinitely, every valid bit is consumed.
// Ports: clk_i/rst_i clock and sync reset; data_i/valid_i/sync_i bit input;
//        sample_o/channel_o/sample_valid_o audio; user_o/user_valid_o user bits;
//        frame_o good-frame strobe; locked_o alignment level; error_o framing-violation strobe.
module adat_frame_deframer
    import adat_pkg::*;
#(
    parameter int LOCK_FRAMES  = 2,
    parameter int SYNC_GAP_MAX = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     data_i,
    input  logic                     valid_i,
    input  logic                     sync_i,
    output logic [ADAT_SAMPLE_W-1:0] sample_o,
    output logic [2:0]               channel_o,
    output logic                     sample_valid_o,
    output logic [3:0]               user_o,
    output logic                     user_valid_o,
    output logic                     frame_o,
    output logic                     locked_o,
    output logic                     error_o
);

    localparam int GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    adat_state_e              state_q, state_d;
    logic [5:0]               group_q, group_d;
    logic [2:0]               ch_q, ch_d;
    logic [4:0]               gap_q, gap_d, gap_inc;
    logic [ADAT_SAMPLE_W-1:0] sr_q, sr_d;
    logic [2:0]               channel_q, channel_d;
    logic [3:0]               user_q, user_d;
    logic                     sample_vld_q, sample_vld_d;
    logic                     user_vld_q, user_vld_d;
    logic                     frame_q, frame_d;
    logic                     error_q, error_d;
    logic [GOOD_W-1:0]        good_q, good_d;
    logic                     start_frame;
    logic                     shift_en, shift_clr, nib_done;
    logic [3:0]               nib;

    // Any accepted sync bit restarts the frame, so the shifter is cleared on it in every state.
    assign shift_en  = valid_i && !sync_i && (state_q == NIBBLE);
    assign shift_clr = valid_i && sync_i;

    adat_nibble_shifter u_shifter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (shift_clr),
        .shift_i  (shift_en),
        .bit_i    (data_i),
        .nibble_o (nib),
        .done_o   (nib_done)
    );

    always_comb begin
        state_d      = state_q;
        group_d      = group_q;
        ch_d         = ch_q;
        gap_d        = gap_q;
        sr_d         = sr_q;
        channel_d    = channel_q;
        user_d       = user_q;
        sample_vld_d = 1'b0;
        user_vld_d   = 1'b0;
        frame_d      = 1'b0;
        error_d      = 1'b0;
        start_frame  = 1'b0;
        gap_inc      = (gap_q == 5'h1f) ? gap_q : gap_q + 5'd1;

        if (valid_i) begin
            case (state_q)
                WAIT_SYNC: start_frame = sync_i;
                MARKER: begin
                    if (sync_i) begin
                        error_d     = 1'b1;
                        start_frame = 1'b1;
                    end else if (!data_i) begin
                        error_d = 1'b1;
                        state_d = WAIT_SYNC;
                    end else begin
                        state_d = NIBBLE;
                    end
                end
                NIBBLE: begin
                    if (sync_i) begin
                        error_d     = 1'b1;
                        start_frame = 1'b1;
                    end else if (nib_done) begin
                        sr_d = {sr_q[ADAT_SAMPLE_W-5:0], nib};
                        if (group_q == 6'd0) begin
                            user_d     = nib;
                            user_vld_d = 1'b1;
                        end else if (is_sample_end(group_q)) begin
                            channel_d    = ch_q;
                            sample_vld_d = 1'b1;
                            // Any violation aborts the frame, so reaching channel 7 implies a clean frame.
                            frame_d      = (ch_q == 3'(ADAT_CHANNELS - 1));
                            ch_d         = ch_q + 3'd1;
                        end
                        if (group_q == 6'(ADAT_GROUPS - 1)) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = MARKER;
                            group_d = group_q + 6'd1;
                        end
                    end
                end
                GAP: begin
                    if (sync_i) begin
                        start_frame = 1'b1;
                    end else if (data_i || (int'(gap_inc) > SYNC_GAP_MAX)) begin
                        error_d = 1'b1;
                        state_d = WAIT_SYNC;
                    end else begin
                        gap_d = gap_inc;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase

            // The sync bit is itself the group-0 marker, so it is checked like any marker.
            if (start_frame) begin
                group_d = '0;
                ch_d    = '0;
                gap_d   = '0;
                sr_d    = '0;
                if (data_i) begin
                    state_d = NIBBLE;
                end else begin
                    error_d = 1'b1;
                    state_d = WAIT_SYNC;
                end
            end
        end

        good_d = good_q;
        if (error_q) begin
            good_d = '0;
        end else if (frame_q && !locked_o) begin
            good_d = good_q + GOOD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= WAIT_SYNC;
            group_q      <= '0;
            ch_q         <= '0;
            gap_q        <= '0;
            sr_q         <= '0;
            channel_q    <= '0;
            user_q       <= '0;
            sample_vld_q <= 1'b0;
            user_vld_q   <= 1'b0;
            frame_q      <= 1'b0;
            error_q      <= 1'b0;
            good_q       <= '0;
        end else begin
            state_q      <= state_d;
            group_q      <= group_d;
            ch_q         <= ch_d;
            gap_q        <= gap_d;
            sr_q         <= sr_d;
            channel_q    <= channel_d;
            user_q       <= user_d;
            sample_vld_q <= sample_vld_d;
            user_vld_q   <= user_vld_d;
            frame_q      <= frame_d;
            error_q      <= error_d;
            good_q       <= good_d;
        end
    end

    // The shift register holds the completed sample in the strobe cycle; between
    // strobes it shows partial data, so sample_o is meaningful only with sample_valid_o.
    assign sample_o       = sr_q;
    assign channel_o      = channel_q;
    assign sample_valid_o = sample_vld_q;
    assign user_o         = user_q;
    assign user_valid_o   = user_vld_q;
    assign frame_o        = frame_q;
    assign error_o        = error_q;
    assign locked_o       = (good_q == GOOD_W'(LOCK_FRAMES));

endmodule

// File: tb/tb_adat_frame_deframer.sv
// Randomized scoreboard bench for adat_frame_deframer.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_adat_frame_deframer;

    localparam int LOCK    = 2;
    localparam int GAP_MAX = 16;

    logic        clk = 1'b0;
    logic        rst, data, valid, sync;
    logic [23:0] sample_o;
    logic [2:0]  channel_o;
    logic [3:0]  user_o;
    logic        sample_valid_o, user_valid_o, frame_o, locked_o, error_o;

    always #5 clk = ~clk;

    adat_frame_deframer #(.LOCK_FRAMES(LOCK), .SYNC_GAP_MAX(GAP_MAX)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (data),
        .valid_i        (valid),
        .sync_i         (sync),
        .sample_o       (sample_o),
        .channel_o      (channel_o),
        .sample_valid_o (sample_valid_o),
        .user_o         (user_o),
        .user_valid_o   (user_valid_o),
        .frame_o        (frame_o),
        .locked_o       (locked_o),
        .error_o        (error_o)
    );

    // Event kinds: 0 user, 1 sample, 2 frame, 3 error.
    typedef struct {
        int          kind;
        int          ch;
        logic [23:0] val;
    } ev_t;

    ev_t         expq[$];
    int          checks = 0;
    int          errors = 0;
    int          model_good = 0;
    logic        lock_exp = 1'b0;
    logic [23:0] smp[8];
    logic [3:0]  usr;
    bit          duty = 1'b0;

    task automatic push(input int k, input int c, input logic [23:0] v);
        ev_t e;
        e.kind = k;
        e.ch   = c;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bit k of a frame built straight from the frame layout: 5-bit groups, marker then nibble MSB-first.
    function automatic logic frame_bit(input int k, input int bad_grp);
        int          g;
        int          p;
        int          j;
        logic [3:0]  n;
        logic [23:0] s;
        g = k / 5;
        p = k % 5;
        if (p == 0) return (g != bad_grp);
        if (g == 0) begin
            n = usr;
        end else begin
            s = smp[(g - 1) / 6];
            j = (g - 1) % 6;
            n = s[23 - 4*j -: 4];
        end
        return n[4 - p];
    endfunction

    task automatic drive_bit(input logic d, input logic s);
        if (duty) begin
            while ($urandom_range(3) != 0) begin
                valid = 1'b0;
                data  = 1'($urandom);
                sync  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        valid = 1'b1;
        data  = d;
        sync  = s;
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = 1'b0;
        sync  = 1'b0;
    endtask

    // Sends the first nbits of a frame; bad_grp >= 0 zeroes that group's marker.
    // trunc_err: a sync will follow the truncated frame, so an early-sync error is expected.
    task automatic send_frame(input int bad_grp, input int nbits, input bit trunc_err);
        int done_grps;
        done_grps = (bad_grp >= 0) ? bad_grp : nbits / 5;
        if (done_grps >= 1) push(0, 0, {20'h0, usr});
        for (int n = 0; n < 8; n++)
            if (6*n + 6 < done_grps) push(1, n, smp[n]);
        if (done_grps == 49) push(2, 0, 24'h0);
        if (bad_grp >= 0 || (nbits < 245 && trunc_err)) push(3, 0, 24'h0);
        for (int k = 0; k < nbits; k++)
            drive_bit(frame_bit(k, bad_grp), k == 0);
    endtask

    task automatic send_gap(input int n);
        if (n > GAP_MAX) push(3, 0, 24'h0);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
    endtask

    task automatic rand_frame();
        for (int n = 0; n < 8; n++) smp[n] = 24'($urandom);
        usr = 4'($urandom);
    endtask

    task automatic spec_frame();
        for (int n = 0; n < 8; n++) smp[n] = 24'hA00000 + 24'(n);
        usr = 4'b1010;
    endtask

    task automatic check_ev(input int k, input int c, input logic [23:0] v);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe kind=%0d ch=%0d val=%h none expected", k, c, v);
            return;
        end
        e = expq.pop_front();
        if (e.kind == 2) model_good = (model_good < LOCK) ? model_good + 1 : LOCK;
        else if (e.kind == 3) model_good = 0;
        if (e.kind != k || e.ch != c || e.val !== v) begin
            errors++;
            $display("FAIL strobe got kind=%0d ch=%0d val=%h expected kind=%0d ch=%0d val=%h",
                     k, c, v, e.kind, e.ch, e.val);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (locked_o !== lock_exp) begin
            errors++;
            $display("FAIL locked got %b expected %b at %0t", locked_o, lock_exp, $time);
        end
        if (user_valid_o === 1'b1)   check_ev(0, 0, {20'h0, user_o});
        if (sample_valid_o === 1'b1) check_ev(1, int'(channel_o), sample_o);
        if (frame_o === 1'b1)        check_ev(2, 0, 24'h0);
        if (error_o === 1'b1)        check_ev(3, 0, 24'h0);
        if (rst === 1'b1) model_good = 0;
        lock_exp = (model_good >= LOCK);
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 1'b0;
        sync  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sample", 32'(sample_o), 32'h0);
        chk("reset_ctl", {21'h0, channel_o, user_o, sample_valid_o, user_valid_o,
                          frame_o, locked_o, error_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-sync bits before the first frame are ignored.
        for (int i = 0; i < 8; i++) drive_bit(1'($urandom), 1'b0);

        spec_frame();
        send_frame(-1, 245, 1'b0);
        send_gap(3);
        send_frame(-1, 245, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("locked_after_two_frames", 32'(locked_o), 32'h1);

        // Longest allowed gap, then a corrupted marker in group 13.
        rand_frame();
        send_gap(GAP_MAX);
        send_frame(-1, 245, 1'b0);
        rand_frame();
        send_frame(13, 245, 1'b0);
        chk("unlocked_after_bad_marker", 32'(locked_o), 32'h0);

        // Early sync at bit 100 restarts on that bit.
        rand_frame();
        send_frame(-1, 245, 1'b0);
        rand_frame();
        send_frame(-1, 100, 1'b1);
        rand_frame();
        send_frame(-1, 245, 1'b0);

        // Gap overrun, then recovery; a '1' in the gap, then recovery.
        send_gap(20);
        rand_frame();
        send_frame(-1, 245, 1'b0);
        send_gap(3);
        push(3, 0, 24'h0);
        drive_bit(1'b1, 1'b0);
        rand_frame();
        send_frame(-1, 245, 1'b0);

        // Sparse valid_i with garbage on idle cycles.
        duty = 1'b1;
        spec_frame();
        send_frame(-1, 245, 1'b0);
        rand_frame();
        send_frame(-1, 245, 1'b0);
        duty = 1'b0;

        // Reset after group 29: samples 0..3 only, then all outputs cleared.
        rand_frame();
        send_frame(-1, 150, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midreset_sample", 32'(sample_o), 32'h0);
        chk("midreset_ctl", {21'h0, channel_o, user_o, sample_valid_o, user_valid_o,
                             frame_o, locked_o, error_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom), 1'b0);
        rand_frame();
        send_frame(-1, 245, 1'b0);
        rand_frame();
        send_frame(-1, 245, 1'b0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("expected_queue_drained", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
